// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared 8:1 strobed mux; registered outputs, two-cycle grant latency.
// Define MUX_RR_ARB_PREEMPT_EN to build the MAX_HOLD preemption counter.
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [7:0] req_i,
  output logic [7:0] gnt_o,
  output logic [2:0] sel_o,
  output logic       strobe_n_o,
  output logic       busy_o,
  output logic [2:0] owner_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, RELEASE} state_t;

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] owner_q, owner_d;
  logic       strobe_n_q, strobe_n_d;
  logic       busy_q, busy_d;

  logic       win_vld;
  logic [2:0] win_idx;
  logic [2:0] cand;
  logic       preempt;

  if (MAX_HOLD == 0 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be in 1..255");
  end

  // Scan owner+1 .. owner+8 (wraps back to owner itself last).
  always_comb begin
    win_vld = 1'b0;
    win_idx = owner_q;
    cand    = '0;
    for (int i = 1; i <= 8; i++) begin
      cand = owner_q + 3'(i);
      if (!win_vld && req_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

`ifdef MUX_RR_ARB_PREEMPT_EN
  localparam logic [7:0] HoldMax = 8'(MAX_HOLD);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP) begin
      cnt_d = '0;
    end else if (state_q == ACTIVE && cnt_q != HoldMax) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // gnt_q is one-hot of the owner while ACTIVE, so this masks the owner out.
  assign preempt = (cnt_q == HoldMax) && (|(req_i & ~gnt_q));
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    owner_d    = owner_q;
    strobe_n_d = strobe_n_q;
    case (state_q)
      IDLE, RELEASE: begin
        gnt_d      = '0;
        strobe_n_d = 1'b1;
        if (win_vld) begin
          state_d = SETUP;
          sel_d   = win_idx;
          owner_d = win_idx;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d    = ACTIVE;
        gnt_d      = 8'd1 << sel_q;
        strobe_n_d = 1'b0;
      end
      ACTIVE: begin
        if (!req_i[sel_q] || preempt) begin
          state_d    = RELEASE;
          gnt_d      = '0;
          strobe_n_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      owner_q    <= 3'd7;
      strobe_n_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      owner_q    <= owner_d;
      strobe_n_q <= strobe_n_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign sel_o      = sel_q;
  assign strobe_n_o = strobe_n_q;
  assign busy_o     = busy_q;
  assign owner_o    = owner_q;

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one 8:1 strobed multiplexer datapath among eight requesters. It picks one requester at a time and drives the mux 3-bit select and its active-low strobe. It also returns a one-hot grant to the winner. Select changes only while the strobe is deasserted, so the shared mux output never glitches between owners.

## Interface
- `MAX_HOLD`, default 15: maximum consecutive ACTIVE cycles before preemption when another request is pending. Range 1..255.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req` in 8: request per requester. Held high while the requester needs the mux.
- `gnt` out 8: one-hot grant. Nonzero only in ACTIVE.
- `sel` out 3: mux select; equals the index of the current or next owner.
- `strobe_n` out 1: mux strobe, active-low. 0 only in ACTIVE.
- `busy` out 1: high in any state other than IDLE.
- `owner` out 3: index of the last granted requester (round-robin pointer).

## Operation
- All outputs are registered. Reset values: `gnt`=0, `sel`=0, `strobe_n`=1, `busy`=0, `owner`=7, state IDLE, hold counter 0.
- States:
  - **IDLE**: if `req`≠0, pick a winner and go to SETUP. Otherwise stay.
  - **SETUP**: `sel` is driven to the winner, `strobe_n`=1 for exactly one cycle, then go to ACTIVE.
  - **ACTIVE**: `strobe_n`=0, `gnt`=one-hot(`sel`), counter increments every cycle while saturating at `MAX_HOLD`.
  - **RELEASE**: `strobe_n`=1, `gnt`=0 for exactly one cycle. Then go to SETUP if a winner exists, else IDLE.
- Winner selection: scan indices `owner`+1, `owner`+2, … modulo 8, and take the first set `req` bit. `owner` is updated to the winner on entry to SETUP.
- ACTIVE exits to RELEASE when either:
  - `req[sel]` drops, or
  - the counter equals `MAX_HOLD` and some other `req` bit is set (preemption).
- If the owner's request stays high with no other request pending, ACTIVE continues indefinitely.
- Winner evaluation in RELEASE uses the `owner` pointer already advanced past the outgoing owner. A preempted requester that still asserts `req` therefore competes last.
- Counter clears on entry to ACTIVE.
- If `req[sel]` drops during SETUP, the FSM still enters ACTIVE for one cycle, then goes to RELEASE. A grant is never cancelled before it is issued.
- `sel` holds its value through RELEASE and IDLE and changes only on entry to SETUP.
- Asserting `reset` mid-grant immediately forces the reset values, including `strobe_n`=1, without waiting for a clock edge.

## Timing
- Grant latency from IDLE: `req` seen at edge 0 → SETUP after edge 1 → `gnt`/`strobe_n`=0 after edge 2. Two cycles.
- Handover: the owner drops `req` at edge n → RELEASE after n+1 → SETUP after n+2 → new ACTIVE after n+3. There are at least two strobe-high cycles between owners.
- Preemption: with a continuous competing request, each owner gets exactly `MAX_HOLD`+1 ACTIVE cycles (counter 0..`MAX_HOLD`).
- Requesters must treat `gnt` as valid in the same cycle that `strobe_n`=0. There is no combinational path from `req` to any output.

## Configuration
- Macro `MUX_RR_ARB_PREEMPT_EN` controls preemption:
  - **Defined**: hold counter and preemption as described above.
  - **Undefined**: no counter is built, and `MAX_HOLD` is ignored. ACTIVE exits only when `req[sel]` drops.
- Round-robin order, latency and reset behaviour are identical in both builds.

## Test plan
- **Reset defaults and first grant**: after reset, drive `req`=8'h01 → `strobe_n`=1 for 2 cycles, then `gnt`=8'h01, `sel`=0, `strobe_n`=0; `owner`=0.
- **Round-robin rotation**: `owner`=0, drop req0, hold `req`=8'h81 → next grant goes to index 7. After req7 drops, the grant goes to index 0.
- **Preemption** (`MUX_RR_ARB_PREEMPT_EN`, `MAX_HOLD`=3): `req`=8'h06 held constant → gnt 8'h02 for 4 cycles, then 2 strobe-high cycles, then 8'h04 for 4 cycles, alternating.
- **No preemption** (macro undefined): same stimulus → `gnt`=8'h02 remains for 50 cycles until req1 drops.
- **Short request**: req3 pulsed for 1 cycle from IDLE → SETUP, one ACTIVE cycle with `gnt`=8'h08, then RELEASE, then IDLE, `busy`=0.
- **Reset mid-grant**: assert `reset` between edges during ACTIVE → `strobe_n`=1 and `gnt`=0 immediately, `owner`=7. After release with `req`=8'hFF, the grant goes to index 0.
